// File: rtl/hilo_mult_ctrl.sv
// HI/LO register file and issue controller for an external Booth multiplier.
// Accepts mult/multu/mthi/mtlo in IDLE; reads combinational, stalled while a multiply is in flight.
module hilo_mult_ctrl #(
    parameter int TIMEOUT_CYC = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        ack,
    output logic        busy,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_stall,
    output logic        mul_start,
    output logic [33:0] mul_a,
    output logic [33:0] mul_b,
    input  logic [67:0] mul_s,
    input  logic        mul_endm,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;
    logic [33:0] r_a;
    logic [33:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_err;
    logic        r_done;
    logic        w_commit;
    logic        w_timeout;
    logic [1:0]  w_ext_a;
    logic [1:0]  w_ext_b;
    logic        w_unused;

    // Product bits above 63 are never architecturally visible.
    assign w_unused = ^mul_s[67:64];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ack       = 1'b0;
        w_commit  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                ack = req;
                if (req && !op[1]) begin
                    w_next = START;
                end
            end
            START: begin
                w_next = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (mul_endm) begin
                    w_commit = 1'b1;
                    w_next   = IDLE;
                end else if (r_cnt == LAST_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_ext_a = op[0] ? 2'b00 : {2{rs_val[31]}};
    assign w_ext_b = op[0] ? 2'b00 : {2{rt_val[31]}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_cnt  <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (ack && !op[1]) begin
                r_a <= {w_ext_a, rs_val};
                r_b <= {w_ext_b, rt_val};
            end
            if (ack && op == 2'b10) begin
                r_hi <= rs_val;
            end
            if (ack && op == 2'b11) begin
                r_lo <= rs_val;
            end
            if (w_commit) begin
                r_hi <= mul_s[63:32];
                r_lo <= mul_s[31:0];
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign mul_start = (r_state == START);
    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign err       = r_err;
    assign done      = r_done;
    assign rd_data   = rd_sel ? r_hi : r_lo;
    assign rd_stall  = rd_req & busy;

endmodule
